// File: rtl/coef_bank_streamer_if.sv
// Bundle of write, control and stream-out signals for coef_bank_streamer.
// master drives the write/control side; slave is the streamer itself.
interface coef_bank_streamer_if #(
   parameter int unsigned DATA_W = 8
);
   logic              wr_en;
   logic [31:0]       wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic              clr;
   logic              start;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [4:0]        out_idx;
   logic [31:0]       loaded;
   logic              busy;
   logic              sel_err;
   logic              done;

   modport master (
      output wr_en, wr_sel, wr_data, clr, start, out_ready,
      input  out_valid, out_data, out_idx, loaded, busy, sel_err, done
   );

   modport slave (
      input  wr_en, wr_sel, wr_data, clr, start, out_ready,
      output out_valid, out_data, out_idx, loaded, busy, sel_err, done
   );
endinterface

// File: rtl/coef_bank_streamer.sv
// 32-entry coefficient bank loaded through a one-hot write port and streamed
// out over a valid/ready handshake once every entry has been written.
module coef_bank_streamer #(
   parameter int unsigned DATA_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   coef_bank_streamer_if.slave  bus
);

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e            state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic [DATA_W-1:0] mem_q [32];
   logic [DATA_W-1:0] mem_d [32];
   logic [31:0]       loaded_q, loaded_d;
   logic              sel_err_q, sel_err_d;
   logic              done_q, done_d;

   logic sel_onehot;
   logic streaming;
   logic xfer;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign sel_onehot = (bus.wr_sel != 32'h0) && ((bus.wr_sel & (bus.wr_sel - 32'h1)) == 32'h0);
   assign streaming  = (state_q == StStream);
   assign xfer       = streaming && bus.out_ready;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mem_d     = mem_q;
      loaded_d  = loaded_q;
      sel_err_d = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.wr_en) begin
               if (sel_onehot) begin
                  for (int i = 0; i < 32; i++) begin
                     if (bus.wr_sel[i]) begin
                        mem_d[i]    = bus.wr_data;
                        loaded_d[i] = 1'b1;
                     end
                  end
               end else begin
                  sel_err_d = 1'b1;
               end
            end
            // clr overrides the loaded flag of a simultaneous write, not its data.
            if (bus.clr) begin
               loaded_d = 32'h0;
            end
            if (bus.start && !bus.clr && (&loaded_q)) begin
               state_d = StStream;
               idx_d   = 5'd0;
            end
         end
         StStream: begin
            if (xfer) begin
               if (idx_q == 5'd31) begin
                  state_d = StIdle;
                  idx_d   = 5'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = 5'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= 5'd0;
         mem_q     <= '{default: '0};
         loaded_q  <= 32'h0;
         sel_err_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mem_q     <= mem_d;
         loaded_q  <= loaded_d;
         sel_err_q <= sel_err_d;
         done_q    <= done_d;
      end
   end

   assign bus.out_valid = streaming;
   assign bus.out_idx   = streaming ? idx_q : 5'd0;
   assign bus.out_data  = streaming ? mem_q[idx_q] : '0;
   assign bus.busy      = streaming;
   assign bus.loaded    = loaded_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_coef_bank_streamer.sv
// Scoreboard bench for coef_bank_streamer: expected beats are queued at start
// and popped as the DUT transfers them.
module tb_coef_bank_streamer;

   localparam int unsigned DATA_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   coef_bank_streamer_if #(.DATA_W(DATA_W)) bus ();

   coef_bank_streamer #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] model_mem [32];
   logic [31:0]       model_loaded;
   logic [12:0]       exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] sel, input logic [DATA_W-1:0] data);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_data = data;
      @(negedge clk);
      bus.wr_en  = 1'b0;
      bus.wr_sel = 32'h0;
   endtask

   task automatic load_all(input logic [DATA_W-1:0] base, input int skip);
      for (int i = 0; i < 32; i++) begin
         if (i != skip) begin
            do_write(32'h1 << i, base + DATA_W'(i));
            model_mem[i]    = base + DATA_W'(i);
            model_loaded[i] = 1'b1;
         end
      end
   endtask

   task automatic start_stream(input bit expect_go);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      if (expect_go) begin
         for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), model_mem[i]});
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_latency_valid", {31'h0, bus.out_valid}, {31'h0, expect_go});
      chk("start_busy", {31'h0, bus.busy}, {31'h0, expect_go});
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
   task automatic run_stream(input int mode, input int wr_at);
      int          cyc = 0;
      int          beats = 0;
      bit          stall = 1'b0;
      bit          wr_pending = 1'b0;
      bit          wr_used = 1'b0;
      logic [4:0]  prev_idx = '0;
      logic [7:0]  prev_data = '0;
      logic [12:0] e;
      logic        rdy;
      while (beats < 32 && cyc < 400) begin
         @(negedge clk);
         bus.wr_en  = 1'b0;
         bus.wr_sel = 32'h0;
         if (wr_pending) begin
            chk("stream_write_no_sel_err", {31'h0, bus.sel_err}, 32'h0);
            wr_pending = 1'b0;
         end
         rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         bus.out_ready = rdy;
         if (bus.out_valid !== 1'b1) begin
            chk("stream_valid_held", {31'h0, bus.out_valid}, 32'h1);
         end
         if (stall) begin
            chk("stall_idx_stable", {27'h0, bus.out_idx}, {27'h0, prev_idx});
            chk("stall_data_stable", {24'h0, bus.out_data}, {24'h0, prev_data});
         end
         if (bus.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_idx", {27'h0, bus.out_idx}, {27'h0, e[12:8]});
               chk("beat_data", {24'h0, bus.out_data}, {24'h0, e[7:0]});
            end
            beats++;
         end
         if (wr_at >= 0 && !wr_used && bus.out_idx == 5'(wr_at)) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 32'h1 << 7;
            bus.wr_data = 8'hAA;
            wr_used     = 1'b1;
            wr_pending  = 1'b1;
         end
         stall     = bus.out_valid && !rdy;
         prev_idx  = bus.out_idx;
         prev_data = bus.out_data;
         cyc++;
      end
      chk("stream_beat_count", 32'(beats), 32'd32);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.wr_en     = 1'b0;
      chk("done_pulse", {31'h0, bus.done}, 32'h1);
      chk("busy_after", {31'h0, bus.busy}, 32'h0);
      chk("valid_after", {31'h0, bus.out_valid}, 32'h0);
      chk("idle_out_idx", {27'h0, bus.out_idx}, 32'h0);
      @(negedge clk);
      chk("done_one_cycle", {31'h0, bus.done}, 32'h0);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_loaded", bus.loaded, 32'h0);
      chk("rst_sel_err", {31'h0, bus.sel_err}, 32'h0);
      chk("rst_done", {31'h0, bus.done}, 32'h0);
      chk("rst_out_data", {24'h0, bus.out_data}, 32'h0);
      chk("rst_out_idx", {27'h0, bus.out_idx}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_loaded = 32'h0;
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
   endtask

   task automatic test_basic_stream();
      load_all(8'h10, -1);
      chk("loaded_full", bus.loaded, 32'hFFFF_FFFF);
      start_stream(1'b1);
      run_stream(0, -1);
   endtask

   task automatic test_backpressure();
      start_stream(1'b1);
      run_stream(1, -1);
   endtask

   task automatic test_sel_err();
      do_write(32'h0000_0000, 8'h77);
      chk("sel_err_zero", {31'h0, bus.sel_err}, 32'h1);
      @(negedge clk);
      chk("sel_err_clear1", {31'h0, bus.sel_err}, 32'h0);
      do_write(32'h0000_0003, 8'h77);
      chk("sel_err_multi", {31'h0, bus.sel_err}, 32'h1);
      @(negedge clk);
      chk("sel_err_clear2", {31'h0, bus.sel_err}, 32'h0);
      chk("sel_err_loaded", bus.loaded, model_loaded);
   endtask

   task automatic test_stream_write_drop();
      start_stream(1'b1);
      run_stream(0, 5);
   endtask

   task automatic test_clr_write();
      @(negedge clk);
      bus.clr     = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 32'h1 << 3;
      bus.wr_data = 8'h55;
      @(negedge clk);
      bus.clr   = 1'b0;
      bus.wr_en = 1'b0;
      model_mem[3] = 8'h55;
      model_loaded = 32'h0;
      chk("clr_wins_loaded", bus.loaded, 32'h0);
   endtask

   task automatic test_partial_load();
      load_all(8'h40, 17);
      chk("partial_loaded", bus.loaded, 32'hFFFD_FFFF);
      start_stream(1'b0);
      @(negedge clk);
      chk("partial_no_valid", {31'h0, bus.out_valid}, 32'h0);
      do_write(32'h1 << 17, 8'h51);
      model_mem[17]    = 8'h51;
      model_loaded[17] = 1'b1;
      start_stream(1'b1);
      run_stream(0, -1);
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      start_stream(1'b1);
      while (cyc < 100 && bus.out_idx != 5'd12) begin
         bus.out_ready = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk("reach_idx12", {27'h0, bus.out_idx}, 32'd12);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid_rst_no_done", {31'h0, bus.done}, 32'h0);
      end
      rst_n = 1'b1;
      exp_q.delete();
      model_loaded = 32'h0;
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      @(negedge clk);
      chk("mid_rst_done_after", {31'h0, bus.done}, 32'h0);
      chk("mid_rst_loaded", bus.loaded, 32'h0);
      start_stream(1'b0);
   endtask

   initial begin
      bus.wr_en     = 1'b0;
      bus.wr_sel    = 32'h0;
      bus.wr_data   = '0;
      bus.clr       = 1'b0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_sel_err();
      test_stream_write_drop();
      test_clr_write();
      test_partial_load();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coef_bank_streamer.md
COEF_BANK_STREAMER -- requirements
Module: coef_bank_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, coefficient word width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port wr_en  input  1  write strobe for one coefficient.
REQ-005 SHALL have port wr_sel  input  32  one-hot entry select, driven by the upstream 5-to-32 decoder.
REQ-006 SHALL have port wr_data  input  DATA_W  coefficient value to store.
REQ-007 SHALL have port clr  input  1  clears all loaded flags.
REQ-008 SHALL have port start  input  1  request to stream all 32 entries.
REQ-009 SHALL have port out_ready  input  1  downstream accept.
REQ-010 SHALL have port out_valid  output  1  out_data/out_idx valid.
REQ-011 SHALL have port out_data  output  DATA_W  streamed coefficient.
REQ-012 SHALL have port out_idx  output  5  index of streamed coefficient.
REQ-013 SHALL have port loaded  output  32  per-entry "written since clr/reset" flags.
REQ-014 SHALL have port busy  output  1  high while in STREAM.
REQ-015 SHALL have port sel_err  output  1  one-cycle pulse on illegal write select.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last entry accepted.

Function
REQ-017 SHALL hold 32 x DATA_W storage entries plus the 32-bit loaded vector.
REQ-018 SHALL implement states IDLE and STREAM only.
REQ-019 Write, IDLE, wr_en=1, wr_sel exactly one-hot at bit i: entry[i] <= wr_data and loaded[i] <= 1 at that edge.
REQ-020 Write with wr_en=1 and wr_sel zero or multi-hot, in IDLE: no storage change; sel_err=1 for the following cycle only.
REQ-021 Any write while in STREAM SHALL be dropped silently; no storage or flag change; no sel_err.
REQ-022 clr=1 in IDLE SHALL zero loaded at that edge; entry contents are retained; clr in STREAM is ignored.
REQ-023 clr and a legal write in the same IDLE cycle: clr wins; loaded becomes all zero, entry[i] is still written.
REQ-024 start=1 in IDLE with loaded==32'hFFFF_FFFF (value before the edge) and clr=0 SHALL enter STREAM with idx=0.
REQ-025 start in IDLE with any loaded bit 0, or with clr=1, SHALL be ignored; state stays IDLE.
REQ-026 start in STREAM SHALL be ignored.
REQ-027 In STREAM: out_valid=1, out_idx=idx, out_data=entry[idx], all combinational from registered idx; busy=1.
REQ-028 First out_valid SHALL appear in the cycle immediately after the edge that sampled start (latency 1).
REQ-029 Handshake: transfer occurs on an edge with out_valid=1 and out_ready=1; idx increments by 1 only on transfer.
REQ-030 out_valid SHALL stay high and out_data/out_idx stable while out_ready=0 (no drop, no change).
REQ-031 Transfer at idx=31: next state IDLE, idx wraps to 0, done=1 for exactly the following cycle; no idx=0 beat is re-emitted.
REQ-032 In IDLE: out_valid=0, busy=0, out_data=0, out_idx=0.
REQ-033 loaded and entry contents SHALL persist across streams; a second start with no clr replays the same 32 values.

Reset
REQ-034 rst_n=0 SHALL asynchronously force: state IDLE, idx 0, all entries 0, loaded 0, out_valid 0, out_data 0, out_idx 0, busy 0, sel_err 0, done 0.
REQ-035 rst_n asserted mid-STREAM SHALL abort immediately with no done pulse; after release the block is in IDLE with loaded=0, so start is ignored until 32 new writes.
REQ-036 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; no write or start is sampled while rst_n=0.

Verification
REQ-037 Write entry[i]=i+8'h10 via one-hot wr_sel for i=0..31, start, out_ready=1 -> 32 consecutive beats idx 0..31 data 8'h10..8'h2F, done one cycle after beat 31, busy low after.
REQ-038 Same load, out_ready toggling 1,0,0,1,... -> each beat held stable while ready=0, no skipped or repeated index, 32 transfers total.
REQ-039 wr_sel=32'h0000_0000 then 32'h0000_0003 with wr_en=1 -> sel_err pulses twice, loaded and entries unchanged.
REQ-040 Load 31 entries (skip bit 17), start -> no out_valid; write entry 17, start -> stream begins next cycle.
REQ-041 During STREAM at idx=5, write wr_sel bit 7 with 8'hAA -> dropped; beat idx 7 shows original value; no sel_err.
REQ-042 rst_n low at idx=12 -> out_valid 0 immediately, no done; after release loaded=0, start ignored.
